// File: rtl/prog_loader.sv
// prog_loader
// -----------------------------------------------------------------------------
// Program loader for the 8-bit CPU. It receives a framed byte stream
// (HDR_BYTE, LEN, LEN data bytes, CSUM) and writes each data byte into the
// instruction memory. The CPU core is held in reset until a frame with a
// matching checksum has been loaded.
//
// A LEN byte of 0 encodes a 256-byte frame. CSUM is the 8-bit sum of the data
// bytes, modulo 256.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   start       one-cycle pulse; aborts a frame in progress or leaves RUN,
//               and re-arms the loader
//   in_valid    byte source has a byte on in_data
//   in_data     stream byte
//   in_ready    loader can accept a byte (in_valid & in_ready = transfer)
//   imem_we     instruction-memory write strobe (one cycle per data byte)
//   imem_addr   instruction-memory write address
//   imem_wdata  instruction-memory write data
//   cpu_reset   active-high reset to the CPU core
//   done        high while the CPU runs a verified image
//   err         sticky checksum-failure flag, cleared by the next header
// -----------------------------------------------------------------------------
module prog_loader #(
  parameter logic [7:0] HDR_BYTE = 8'hA5,
  parameter int         ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    WAIT_HDR,
    LEN,
    DATA,
    CSUM,
    RUN
  } state_t;

  state_t            state, state_n;
  logic [8:0]        cnt, cnt_n;       // remaining data bytes, 1..256
  logic [7:0]        sum, sum_n;       // running checksum of data bytes
  logic [ADDR_W-1:0] addr, addr_n;     // address of the next data byte
  logic              we_n;
  logic [ADDR_W-1:0] waddr_n;
  logic [7:0]        wdata_n;
  logic              err_n;
  logic              accept;

  // in_ready is registered, so it already reflects whether this state takes bytes.
  assign accept = in_valid & in_ready;

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; an unassigned path would infer a latch.
    state_n = state;
    cnt_n   = cnt;
    sum_n   = sum;
    addr_n  = addr;
    we_n    = 1'b0;
    waddr_n = imem_addr;
    wdata_n = imem_wdata;
    err_n   = err;

    unique case (state)
      WAIT_HDR: begin
        // start has no effect here; junk bytes are simply dropped.
        if (accept && in_data == HDR_BYTE) begin
          state_n = LEN;
          err_n   = 1'b0;
        end
      end

      LEN: begin
        if (start) begin
          state_n = WAIT_HDR;
        end else if (accept) begin
          cnt_n   = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
          addr_n  = '0;
          sum_n   = 8'd0;
          state_n = DATA;
        end
      end

      DATA: begin
        // start wins over a byte accepted on the same edge: nothing is written.
        if (start) begin
          state_n = WAIT_HDR;
        end else if (accept) begin
          we_n    = 1'b1;
          waddr_n = addr;
          wdata_n = in_data;
          addr_n  = addr + 1'b1;  // wraps 255 -> 0 only at the end of a 256-byte frame
          sum_n   = sum + in_data;
          cnt_n   = cnt - 9'd1;
          if (cnt == 9'd1) state_n = CSUM;
        end
      end

      CSUM: begin
        if (start) begin
          state_n = WAIT_HDR;
        end else if (accept) begin
          if (in_data == sum) begin
            state_n = RUN;
          end else begin
            state_n = WAIT_HDR;
            err_n   = 1'b1;
          end
        end
      end

      RUN: begin
        if (start) state_n = WAIT_HDR;
      end

      default: state_n = WAIT_HDR;
    endcase
  end

  // State and registered outputs. The handshake and CPU-control outputs are
  // decoded from the next state, so they change on the same edge as the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= WAIT_HDR;
      cnt        <= 9'd0;
      sum        <= 8'd0;
      addr       <= '0;
      in_ready   <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 8'd0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values, independent of statement order.
      state      <= state_n;
      cnt        <= cnt_n;
      sum        <= sum_n;
      addr       <= addr_n;
      in_ready   <= (state_n != RUN);
      imem_we    <= we_n;
      imem_addr  <= waddr_n;
      imem_wdata <= wdata_n;
      cpu_reset  <= (state_n != RUN);
      done       <= (state_n == RUN);
      err        <= err_n;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
// -----------------------------------------------------------------------------
// Directed bench for prog_loader. Inputs are driven and outputs sampled on the
// falling clock edge; a monitor records every instruction-memory write into a
// shadow memory so whole-image loads can be checked.
// -----------------------------------------------------------------------------
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       imem_we;
  logic [7:0] imem_addr;
  logic [7:0] imem_wdata;
  logic       cpu_reset;
  logic       done;
  logic       err;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int wr_count  = 0;
  logic [7:0] tb_mem [256];

  prog_loader #(.HDR_BYTE(8'hA5), .ADDR_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Write monitor: at a rising edge the strobe still holds the previous
  // cycle's value, so each strobe is counted exactly once.
  always @(posedge clk) begin
    if (imem_we) begin
      wr_count = wr_count + 1;
      tb_mem[imem_addr] = imem_wdata;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one byte for exactly one cycle, starting at a falling edge.
  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #2 reset = 1'b0;
    #1;
    total_cnt++; if ({in_ready, imem_we, cpu_reset, done, err} !== 5'b10100)
      $display("FAIL reset_flags: got rdy/we/crst/done/err=%b want 10100",
               {in_ready, imem_we, cpu_reset, done, err}); else pass_cnt++;
    total_cnt++; if ({imem_addr, imem_wdata} !== 16'h0000)
      $display("FAIL reset_bus: got addr=%h wdata=%h want 00 00", imem_addr, imem_wdata); else pass_cnt++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    send(8'hA5);
    total_cnt++; if (imem_we !== 1'b0 || cpu_reset !== 1'b1)
      $display("FAIL basic_hdr: got we=%b crst=%b want 0 1", imem_we, cpu_reset); else pass_cnt++;
    send(8'h03);
    total_cnt++; if (imem_we !== 1'b0)
      $display("FAIL basic_len_we: got %b want 0", imem_we); else pass_cnt++;
    send(8'h11);
    total_cnt++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 8'h00, 8'h11})
      $display("FAIL basic_w0: got we=%b a=%h d=%h want 1 00 11", imem_we, imem_addr, imem_wdata); else pass_cnt++;
    send(8'h22);
    total_cnt++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 8'h01, 8'h22})
      $display("FAIL basic_w1: got we=%b a=%h d=%h want 1 01 22", imem_we, imem_addr, imem_wdata); else pass_cnt++;
    send(8'h33);
    total_cnt++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 8'h02, 8'h33})
      $display("FAIL basic_w2: got we=%b a=%h d=%h want 1 02 33", imem_we, imem_addr, imem_wdata); else pass_cnt++;
    total_cnt++; if (cpu_reset !== 1'b1 || done !== 1'b0)
      $display("FAIL basic_pre_run: got crst=%b done=%b want 1 0", cpu_reset, done); else pass_cnt++;
    send(8'h66);
    total_cnt++; if ({imem_we, cpu_reset, done, in_ready} !== 4'b0010)
      $display("FAIL basic_run: got we/crst/done/rdy=%b want 0010",
               {imem_we, cpu_reset, done, in_ready}); else pass_cnt++;
  endtask

  task automatic test_start_run();
    pulse_start();
    total_cnt++; if ({cpu_reset, done, in_ready} !== 3'b101)
      $display("FAIL start_run: got crst/done/rdy=%b want 101", {cpu_reset, done, in_ready}); else pass_cnt++;
  endtask

  task automatic test_bad_csum();
    send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h31);
    total_cnt++; if ({err, cpu_reset, done, in_ready} !== 4'b1101)
      $display("FAIL badcsum_flags: got err/crst/done/rdy=%b want 1101",
               {err, cpu_reset, done, in_ready}); else pass_cnt++;
    send(8'hA5);
    total_cnt++; if (err !== 1'b0)
      $display("FAIL badcsum_err_clear: got %b want 0", err); else pass_cnt++;
    send(8'h01);
    send(8'h05);
    total_cnt++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 8'h00, 8'h05})
      $display("FAIL badcsum_retry_w: got we=%b a=%h d=%h want 1 00 05", imem_we, imem_addr, imem_wdata); else pass_cnt++;
    send(8'h05);
    total_cnt++; if ({done, cpu_reset, err} !== 3'b100)
      $display("FAIL badcsum_retry_run: got done/crst/err=%b want 100", {done, cpu_reset, err}); else pass_cnt++;
    pulse_start();
  endtask

  task automatic test_junk();
    int wr0;
    wr0 = wr_count;
    send(8'h00); send(8'hFF);
    total_cnt++; if (imem_we !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL junk_ignored: got we=%b rdy=%b want 0 1", imem_we, in_ready); else pass_cnt++;
    send(8'hA5); send(8'h01); send(8'h7F);
    total_cnt++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 8'h00, 8'h7F})
      $display("FAIL junk_w0: got we=%b a=%h d=%h want 1 00 7f", imem_we, imem_addr, imem_wdata); else pass_cnt++;
    send(8'h7F);
    total_cnt++; if (done !== 1'b1 || wr_count - wr0 !== 1)
      $display("FAIL junk_run: got done=%b writes=%0d want 1 1", done, wr_count - wr0); else pass_cnt++;
    pulse_start();
  endtask

  task automatic test_len256();
    int wr0;
    int bad;
    for (int i = 0; i < 256; i++) tb_mem[i] = 8'hEE;
    wr0 = wr_count;
    bad = 0;
    send(8'hA5); send(8'h00);
    for (int i = 0; i < 256; i++) begin
      send(8'h01);
      total_cnt++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, i[7:0], 8'h01})
        $display("FAIL len256_w%0d: got we=%b a=%h d=%h want 1 %h 01",
                 i, imem_we, imem_addr, imem_wdata, i[7:0]); else pass_cnt++;
    end
    send(8'h00);
    total_cnt++; if ({done, cpu_reset, imem_we} !== 3'b100)
      $display("FAIL len256_run: got done/crst/we=%b want 100", {done, cpu_reset, imem_we}); else pass_cnt++;
    for (int i = 0; i < 256; i++) if (tb_mem[i] !== 8'h01) bad++;
    total_cnt++; if (wr_count - wr0 !== 256 || bad !== 0)
      $display("FAIL len256_image: got writes=%0d bad=%0d want 256 0", wr_count - wr0, bad); else pass_cnt++;
    pulse_start();
  endtask

  task automatic test_abort();
    int wr0;
    send(8'hA5); send(8'h05); send(8'hAA); send(8'hBB);
    // start and a valid byte on the same edge: start wins.
    in_valid = 1'b1; in_data = 8'hCC; start = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; start = 1'b0;
    total_cnt++; if (imem_we !== 1'b0 || err !== 1'b0)
      $display("FAIL abort_edge: got we=%b err=%b want 0 0", imem_we, err); else pass_cnt++;
    wr0 = wr_count;
    send(8'h01); send(8'h02);
    @(negedge clk);
    total_cnt++; if (wr_count !== wr0 || done !== 1'b0 || cpu_reset !== 1'b1)
      $display("FAIL abort_no_writes: got writes=%0d done=%b crst=%b want 0 0 1",
               wr_count - wr0, done, cpu_reset); else pass_cnt++;
    send(8'hA5); send(8'h01); send(8'h09); send(8'h09);
    total_cnt++; if (done !== 1'b1 || tb_mem[0] !== 8'h09)
      $display("FAIL abort_reload: got done=%b mem0=%h want 1 09", done, tb_mem[0]); else pass_cnt++;
    pulse_start();
  endtask

  task automatic test_reset_mid();
    int wr0;
    send(8'hA5); send(8'h08); send(8'h41); send(8'h42);
    // Random pauses; at most four more bytes, so the frame stays in DATA.
    for (int i = 0; i < 4; i++) begin
      in_valid = (i == 3) ? 1'b1 : 1'($urandom_range(0, 1));
      in_data  = 8'($urandom_range(0, 127));
      @(negedge clk);
    end
    in_valid = 1'b0;
    total_cnt++; if (imem_we !== 1'b1)
      $display("FAIL rstmid_pre_we: got %b want 1", imem_we); else pass_cnt++;
    #2 reset = 1'b0;
    #1;
    total_cnt++; if ({in_ready, imem_we, cpu_reset, done, err, imem_addr, imem_wdata} !== {5'b10100, 16'h0000})
      $display("FAIL rstmid_async: got rdy/we/crst/done/err=%b a=%h d=%h want 10100 00 00",
               {in_ready, imem_we, cpu_reset, done, err}, imem_addr, imem_wdata); else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    wr0 = wr_count;
    // Non-header bytes (all below A5) with random gaps must produce no writes.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom_range(0, 127));
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (wr_count !== wr0 || imem_we !== 1'b0)
      $display("FAIL rstmid_no_writes: got writes=%0d we=%b want 0 0", wr_count - wr0, imem_we); else pass_cnt++;
    send(8'hA5); send(8'h02); send(8'h01);
    send(8'h02);
    total_cnt++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 8'h01, 8'h02})
      $display("FAIL rstmid_new_w1: got we=%b a=%h d=%h want 1 01 02", imem_we, imem_addr, imem_wdata); else pass_cnt++;
    send(8'h03);
    total_cnt++; if (done !== 1'b1)
      $display("FAIL rstmid_new_run: got done=%b want 1", done); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_run();
    test_bad_csum();
    test_junk();
    test_len256();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream stage of the 8-bit CPU: receives a program image as a framed byte stream and writes it into the CPU instruction memory.
- Holds the CPU core in reset while loading, then releases it only after a checksum-verified load.
- Sits between a byte source (UART receiver or bench driver) and the instruction-memory write port plus the core's reset input.

Parameters:
- HDR_BYTE, 8'hA5, frame start marker.
- ADDR_W, 8, instruction-memory address width (256 instructions).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low; low = reset.
- start  input  1  single-cycle pulse; aborts or ends RUN and re-arms the loader.
- in_valid  input  1  source has a byte on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte; transfer occurs on a rising edge with in_valid & in_ready.
- imem_we  output  1  instruction-memory write strobe.
- imem_addr  output  ADDR_W  write address.
- imem_wdata  output  8  write data (one instruction).
- cpu_reset  output  1  active-high reset to the CPU core.
- done  output  1  high while the CPU runs a verified image.
- err  output  1  sticky checksum-failure flag.

Behaviour:
- Frame format: HDR_BYTE, LEN, LEN data bytes, CSUM.
  - LEN = 0 means 256 bytes.
  - CSUM = 8-bit sum of the data bytes, modulo 256.
- All outputs are registered. Reset values apply immediately on reset low, independent of clk:
  - state = WAIT_HDR, in_ready = 1, imem_we = 0, imem_addr = 0, imem_wdata = 0, cpu_reset = 1, done = 0, err = 0.
  - Internal counter and sum are cleared.
- States: WAIT_HDR, LEN, DATA, CSUM, RUN.
- WAIT_HDR:
  - Accepted byte == HDR_BYTE -> LEN, and err clears.
  - Any other accepted byte is discarded; stay in WAIT_HDR.
- LEN:
  - Accepted byte loads the remaining count (0 loads 256).
  - Clears address and sum -> DATA.
- DATA, per accepted byte:
  - Next cycle: imem_we = 1 for exactly one cycle, imem_addr = current address, imem_wdata = byte.
  - Address increments, sum += byte (mod 256).
  - When the last byte is accepted -> CSUM.
  - Back-to-back accepts give consecutive single-cycle strobes.
- CSUM:
  - Accepted byte == sum -> RUN.
  - Mismatch -> WAIT_HDR with err = 1 and cpu_reset remaining 1.
- RUN:
  - in_ready = 0, cpu_reset = 0, done = 1.
  - All three change in the cycle after the CSUM accept edge.
- in_ready is 1 in every state except RUN. The block never stalls mid-frame.
- in_valid low simply pauses the frame. There is no timeout.
- start in RUN -> WAIT_HDR: cpu_reset = 1 and done = 0 on the next edge.
- start in LEN/DATA/CSUM:
  - Aborts to WAIT_HDR.
  - Partially written memory is left as is; err unchanged.
  - start wins over a byte accepted on the same edge.
- start in WAIT_HDR: no effect.
- Address wraps 255 -> 0. This can only occur at the end of a 256-byte frame.
- Reset low mid-frame: frame discarded, outputs to reset values, memory contents untouched.
- cpu_reset is never 0 unless the most recent frame passed its checksum.

Test Plan:
- Reset release, then stream A5 03 11 22 33 66 -> writes (0,11), (1,22), (2,33) on three single-cycle imem_we strobes, one cycle after each accept. One cycle after the 66 accept: cpu_reset = 0, done = 1, in_ready = 0.
- Stream A5 02 10 20 31 (bad CSUM; expected 30) -> err = 1, cpu_reset stays 1, returns to WAIT_HDR. A following good frame A5 01 05 05 clears err and reaches RUN.
- Leading junk 00 FF A5 01 7F 7F -> junk ignored, single write (0,7F), RUN reached.
- LEN = 00 with 256 bytes of value 01, CSUM 00 -> 256 writes at addresses 0..255, RUN reached.
- start pulse while in RUN -> next edge cpu_reset = 1, done = 0, in_ready = 1. start pulse after two data bytes -> back to WAIT_HDR, no further writes.
- reset low mid-DATA with in_valid toggling randomly -> outputs take reset values asynchronously before the next clk edge. No imem_we afterwards until a new frame arrives.
